// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and frame constants.
// The optional checksum byte is enabled with the IMEM_LOADER_CHECKSUM_EN macro.
package imem_loader_pkg;

  localparam logic [7:0] START_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses START | LEN | DATA [| CHK] frames and writes LE words to imem.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the data.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INST_MEMORY_SIZE = 16384,
  parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
  parameter int BASE_ADDR        = 0,
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  imem_w_en,
  output logic [ADDR_WIDTH-1:0] imem_write_addr,
  output logic [31:0]           imem_write_data,
  output logic                  cpu_stall,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [33:0]           CAPACITY_BYTES = 34'(INST_MEMORY_SIZE - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE_A         = ADDR_WIDTH'(BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CHK;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  state_e                state_q, state_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           shift_q, shift_d;
  logic [TW-1:0]         timeout_q, timeout_d;
  logic                  err_q, err_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic [31:0] assembled;
  logic [33:0] len_bytes;
  logic        last_byte;
  logic        timed_out;

  // Incoming bytes enter at the top so that after four bytes byte0 sits in [7:0].
  assign assembled = {in_data, shift_q[31:8]};
  assign len_bytes = {assembled, 2'b00};
  assign last_byte = (byte_cnt_q == 2'd3);
  assign timed_out = (state_q != ST_IDLE) && !in_valid &&
                     (timeout_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    err_d      = err_q;
    w_en_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    timeout_d  = (in_valid || state_q == ST_IDLE) ? '0 : timeout_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_data == START_BYTE) begin
          state_d    = ST_LEN;
          err_d      = 1'b0;
          byte_cnt_d = 2'd0;
          shift_d    = '0;
          word_cnt_d = '0;
          len_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end

      ST_LEN: begin
        if (in_valid) begin
          shift_d    = assembled;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            len_d = assembled;
            if (assembled == 32'd0) begin
              state_d = ST_AFTER_DATA;
            end else if (len_bytes > CAPACITY_BYTES) begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (in_valid) begin
          shift_d    = assembled;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + in_data;
`endif
          if (last_byte) begin
            w_en_d     = 1'b1;
            addr_d     = BASE_A + ADDR_WIDTH'({word_cnt_q, 2'b00});
            wdata_d    = assembled;
            word_cnt_d = word_cnt_q + 32'd1;
            if (word_cnt_q == len_q - 32'd1) begin
              state_d = ST_AFTER_DATA;
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (in_valid) begin
          err_d   = (in_data != sum_q);
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // An expired inter-byte gap abandons the frame; words already written are kept.
    if (timed_out) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      timeout_q  <= '0;
      err_q      <= 1'b0;
      w_en_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      w_en_q     <= w_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Stall covers the frame body only, so it is already low in the DONE cycle.
  assign cpu_stall       = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign load_done       = (state_q == ST_DONE);
  assign load_err        = err_q;
  assign imem_w_en       = w_en_q;
  assign imem_write_addr = addr_q;
  assign imem_write_data = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; exercises the checksum byte when
// IMEM_LOADER_CHECKSUM_EN is defined for the build.
module tb_imem_loader;

  localparam int MEM_SIZE = 16384;
  localparam int AW       = 14;
  localparam int TO       = 40;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          imem_w_en;
  logic [AW-1:0] imem_write_addr;
  logic [31:0]   imem_write_data;
  logic          cpu_stall;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            done_cnt = 0;

  imem_loader #(
    .INST_MEMORY_SIZE(MEM_SIZE),
    .ADDR_WIDTH      (AW),
    .BASE_ADDR       (0),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .imem_w_en      (imem_w_en),
    .imem_write_addr(imem_write_addr),
    .imem_write_data(imem_write_data),
    .cpu_stall      (cpu_stall),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_w_en === 1'b1) begin
      wr_addr.push_back(imem_write_addr);
      wr_data.push_back(imem_write_data);
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (imem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_en: got %b expected 0", imem_w_en); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", cpu_stall); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", load_err); end
    checks++; if (imem_write_addr !== 14'h0 || imem_write_data !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_addr_data: got %h/%h expected 0/0", imem_write_addr, imem_write_data);
    end
    rst = 1'b0;
    idle_cycles(2);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_stall: got %b expected 0", cpu_stall); end
  endtask

  task automatic test_basic_load();
    int wb;
    int db;
    logic [AW-1:0] a;
    logic [31:0]   d;
    wb = wr_addr.size();
    db = done_cnt;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL basic_stall_before: got %b expected 0", cpu_stall); end
    send_byte(8'hA5);
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL basic_stall_after_start: got %b expected 1", cpu_stall); end
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hB6);
`endif
    idle_cycles(4);
    checks++; if (wr_addr.size() - wb !== 2) begin errors++; $display("[TB] FAIL basic_write_count: got %0d expected 2", wr_addr.size() - wb); end
    a = (wr_addr.size() > wb) ? wr_addr[wb] : 'x;
    d = (wr_data.size() > wb) ? wr_data[wb] : 'x;
    checks++; if (a !== 14'h000 || d !== 32'h00000013) begin
      errors++; $display("[TB] FAIL basic_word0: got %h/%h expected 000/00000013", a, d);
    end
    a = (wr_addr.size() > wb + 1) ? wr_addr[wb+1] : 'x;
    d = (wr_data.size() > wb + 1) ? wr_data[wb+1] : 'x;
    checks++; if (a !== 14'h004 || d !== 32'h00100093) begin
      errors++; $display("[TB] FAIL basic_word1: got %h/%h expected 004/00100093", a, d);
    end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_cnt - db); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b expected 0", load_err); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL basic_stall_end: got %b expected 0", cpu_stall); end
  endtask

  task automatic test_zero_len();
    int wb;
    int db;
    wb = wr_addr.size();
    db = done_cnt;
    send_byte(8'hA5);
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL zero_stall_after_start: got %b expected 1", cpu_stall); end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL zero_stall_in_chk: got %b expected 1", cpu_stall); end
    send_byte(8'h00);
`endif
    checks++; if (load_done !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_done_cycle: got done=%b stall=%b expected done=1 stall=0", load_done, cpu_stall);
    end
    // START arriving in the DONE cycle must be dropped.
    send_byte(8'hA5);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL zero_start_in_done_dropped: got %b expected 0", cpu_stall); end
    send_byte(8'h13);
    idle_cycles(3);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle_byte_ignored: got %b expected 0", cpu_stall); end
    checks++; if (wr_addr.size() - wb !== 0) begin errors++; $display("[TB] FAIL zero_no_writes: got %0d expected 0", wr_addr.size() - wb); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("[TB] FAIL zero_done_pulses: got %0d expected 1", done_cnt - db); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL zero_err: got %b expected 0", load_err); end
  endtask

  task automatic test_len_overflow();
    int wb;
    int db;
    // 4096 words exactly fills the memory and must be accepted.
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    checks++; if (cpu_stall !== 1'b1 || load_err !== 1'b0) begin
      errors++; $display("[TB] FAIL len_4096_accepted: got stall=%b err=%b expected stall=1 err=0", cpu_stall, load_err);
    end
    pulse_reset();
    wb = wr_addr.size();
    db = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    checks++; if (load_err !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL len_4097_rejected: got err=%b stall=%b expected err=1 stall=0", load_err, cpu_stall);
    end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle_cycles(3);
    checks++; if (wr_addr.size() - wb !== 0) begin errors++; $display("[TB] FAIL len_4097_no_writes: got %0d expected 0", wr_addr.size() - wb); end
    checks++; if (done_cnt - db !== 0) begin errors++; $display("[TB] FAIL len_4097_no_done: got %0d expected 0", done_cnt - db); end
    // Huge count with top bits set must not wrap past the check.
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    checks++; if (load_err !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL len_wrap_rejected: got err=%b stall=%b expected err=1 stall=0", load_err, cpu_stall);
    end
  endtask

  task automatic test_timeout();
    int wb;
    int db;
    logic [AW-1:0] a;
    logic [31:0]   d;
    wb = wr_addr.size();
    db = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    idle_cycles(TO - 1);
    checks++; if (cpu_stall !== 1'b1 || load_err !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_not_yet: got stall=%b err=%b expected stall=1 err=0", cpu_stall, load_err);
    end
    idle_cycles(1);
    checks++; if (cpu_stall !== 1'b0 || load_err !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_fired: got stall=%b err=%b expected stall=0 err=1", cpu_stall, load_err);
    end
    idle_cycles(3);
    checks++; if (wr_addr.size() - wb !== 0 || done_cnt - db !== 0) begin
      errors++; $display("[TB] FAIL timeout_side_effects: got writes=%0d dones=%0d expected 0/0", wr_addr.size() - wb, done_cnt - db);
    end
    send_byte(8'hA5);
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_cleared_on_start: got %b expected 0", load_err); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h14);
`endif
    idle_cycles(3);
    a = (wr_addr.size() > wb) ? wr_addr[wb] : 'x;
    d = (wr_data.size() > wb) ? wr_data[wb] : 'x;
    checks++; if (a !== 14'h000 || d !== 32'h12345678) begin
      errors++; $display("[TB] FAIL timeout_reload_word: got %h/%h expected 000/12345678", a, d);
    end
    checks++; if (done_cnt - db !== 1 || load_err !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_reload_done: got dones=%0d err=%b expected 1/0", done_cnt - db, load_err);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int wb;
    int db;
    logic [31:0] d;
    wb = wr_addr.size();
    db = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0A);
    idle_cycles(2);
    d = (wr_data.size() > wb) ? wr_data[wb] : 'x;
    checks++; if (d !== 32'h04030201) begin errors++; $display("[TB] FAIL chk_good_word: got %h expected 04030201", d); end
    checks++; if (done_cnt - db !== 1 || load_err !== 1'b0) begin
      errors++; $display("[TB] FAIL chk_good: got dones=%0d err=%b expected 1/0", done_cnt - db, load_err);
    end
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0B);
    idle_cycles(2);
    checks++; if (done_cnt - db !== 2 || load_err !== 1'b1) begin
      errors++; $display("[TB] FAIL chk_bad: got dones=%0d err=%b expected 2/1", done_cnt - db, load_err);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int wb;
    int db;
    logic [AW-1:0] a;
    logic [31:0]   d;
    wb = wr_addr.size();
    db = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    pulse_reset();
    checks++; if (cpu_stall !== 1'b0 || load_err !== 1'b0 || imem_w_en !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_outputs: got stall=%b err=%b wen=%b expected 0/0/0", cpu_stall, load_err, imem_w_en);
    end
    idle_cycles(2);
    checks++; if (wr_addr.size() - wb !== 1 || done_cnt - db !== 0) begin
      errors++; $display("[TB] FAIL rst_mid_counts: got writes=%0d dones=%0d expected 1/0", wr_addr.size() - wb, done_cnt - db);
    end
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hAA);
`endif
    idle_cycles(3);
    a = (wr_addr.size() > wb + 1) ? wr_addr[wb+1] : 'x;
    d = (wr_data.size() > wb + 1) ? wr_data[wb+1] : 'x;
    checks++; if (a !== 14'h000 || d !== 32'h11223344) begin
      errors++; $display("[TB] FAIL rst_mid_reload_word: got %h/%h expected 000/11223344", a, d);
    end
    checks++; if (done_cnt - db !== 1 || load_err !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_reload_done: got dones=%0d err=%b expected 1/0", done_cnt - db, load_err);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    $display("[TB] starting imem_loader bench");
    test_reset();
    test_basic_load();
    test_zero_len();
    test_len_overflow();
    test_timeout();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
